lsu_mem_initiator: RTL and testbench

- Load/store initiator in the MEM stage: accepts one load/store request from the pipeline and drives the byte-addressed data memory port (mode/addr/wdata/we in, combinational rdata out).
- Issues every store as byte writes, lowest address first; memory contents are little-endian.
- Splits misaligned loads into byte reads and assembles and extends the result.
- Returns one response per request and holds req_ready low while busy, so it stalls the pipeline.

---
 rtl/lsu_mem_initiator_if.sv | 45 ++++
 rtl/lsu_mem_initiator.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_initiator_if.sv
// Bundle between the MEM-stage pipeline, the load/store initiator and the
// byte-addressed data memory port.
//   req_*  : one load/store request (valid/ready handshake)
//   resp_* : one-cycle response pulse with result, tag and error flag
//   mem_*  : memory port (mode/addr/wdata/we out, combinational rdata in)
// slave  : initiator view (takes requests, drives responses and the memory port)
// master : pipeline + memory view (the other side of every signal)
interface lsu_mem_initiator_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [4:0]       req_rd;

  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic [4:0]       resp_rd;
  logic             resp_err;

  logic [2:0]       mem_mode;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_err,
    output mem_mode, mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_err,
    input  mem_mode, mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator. Takes one request at a time, drives the
// byte-addressed memory port for 1..4 beats and returns a single response.
// Stores always go out as byte writes (lowest address first); misaligned
// loads are split into unsigned byte reads and reassembled here.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   lsu  : request / response / memory bundle (slave modport)
module lsu_mem_initiator #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  lsu_mem_initiator_if.slave  lsu
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RESP} state_t;

  localparam logic [2:0] M_IDLE  = 3'b000;
  localparam logic [2:0] M_WORD  = 3'b001;
  localparam logic [2:0] M_HALF  = 3'b010;
  localparam logic [2:0] M_BYTE  = 3'b011;
  localparam logic [2:0] M_UHALF = 3'b100;
  localparam logic [2:0] M_UBYTE = 3'b101;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]       rd_q, rd_d;
  logic             split_q, split_d;   // misaligned load done bytewise
  logic [1:0]       last_q, last_d;     // index of the final beat
  logic [1:0]       k_q, k_d;           // current beat
  logic [WIDTH-1:0] asm_q, asm_d;       // bytes gathered by a split load
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]       resp_rd_q, resp_rd_d;
  logic             resp_err_q, resp_err_d;

  logic             mem_we_raw;
  logic [WIDTH-1:0] beat_addr;
  logic [7:0]       beat_byte;
  logic [4:0]       k_bit;
  logic             req_legal;
  logic             req_misal;
  logic [WIDTH-1:0] ld_result;

  always_comb begin
    if (lsu.req_we) req_legal = (lsu.req_funct3 <= 3'b010);
    else            req_legal = (lsu.req_funct3 != 3'b011) &&
                                (lsu.req_funct3 != 3'b110) &&
                                (lsu.req_funct3 != 3'b111);
  end

  // Only loads can be misaligned: stores are bytewise anyway.
  assign req_misal = !lsu.req_we &&
                     (((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                      ((lsu.req_funct3 == 3'b010) && (lsu.req_addr[1:0] != 2'b00)));

  // Wraps modulo 2^WIDTH, so a beat past 0xFFFFFFFF lands on 0.
  assign beat_addr = addr_q + {{(WIDTH-2){1'b0}}, k_q};
  assign beat_byte = lsu.mem_rdata[7:0];
  assign k_bit     = {k_q, 3'b000};

  // Final-beat result: the byte read in this cycle is the top byte of the
  // assembled value, the earlier ones already sit in asm_q.
  always_comb begin
    ld_result = '0;
    if (!we_q) begin
      if (!split_q) begin
        ld_result = lsu.mem_rdata;
      end else begin
        case (f3_q)
          3'b001:  ld_result = {{16{beat_byte[7]}}, beat_byte, asm_q[7:0]};
          3'b101:  ld_result = {16'b0, beat_byte, asm_q[7:0]};
          default: ld_result = {beat_byte, asm_q[23:0]};
        endcase
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    split_d      = split_q;
    last_d       = last_q;
    k_d          = k_q;
    asm_d        = asm_q;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    lsu.req_ready  = 1'b0;
    lsu.resp_valid = 1'b0;
    lsu.mem_mode   = M_IDLE;
    lsu.mem_addr   = '0;
    lsu.mem_wdata  = '0;
    mem_we_raw     = 1'b0;

    case (state_q)
      S_IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) begin
          we_d    = lsu.req_we;
          f3_d    = lsu.req_funct3;
          addr_d  = lsu.req_addr;
          wdata_d = lsu.req_wdata;
          rd_d    = lsu.req_rd;
          split_d = req_misal;
          k_d     = 2'd0;
          asm_d   = '0;
          if (lsu.req_we)
            last_d = (lsu.req_funct3[1:0] == 2'b10) ? 2'd3 :
                     (lsu.req_funct3[0] ? 2'd1 : 2'd0);
          else if (req_misal)
            last_d = lsu.req_funct3[1] ? 2'd3 : 2'd1;
          else
            last_d = 2'd0;
          if (req_legal) begin
            state_d = S_BEAT;
          end else begin
            state_d      = S_RESP;
            resp_rdata_d = '0;
            resp_rd_d    = lsu.req_rd;
            resp_err_d   = 1'b1;
          end
        end
      end

      S_BEAT: begin
        lsu.mem_addr = beat_addr;
        if (we_q) begin
          lsu.mem_mode  = M_BYTE;
          lsu.mem_wdata = {{(WIDTH-8){1'b0}}, wdata_q[k_bit +: 8]};
          mem_we_raw    = 1'b1;
        end else if (split_q) begin
          lsu.mem_mode = M_UBYTE;
        end else begin
          case (f3_q)
            3'b010:  lsu.mem_mode = M_WORD;
            3'b001:  lsu.mem_mode = M_HALF;
            3'b100:  lsu.mem_mode = M_UBYTE;
            3'b101:  lsu.mem_mode = M_UHALF;
            default: lsu.mem_mode = M_BYTE;
          endcase
        end
        asm_d[k_bit +: 8] = beat_byte;
        if (k_q == last_q) begin
          state_d      = S_RESP;
          resp_rdata_d = ld_result;
          resp_rd_d    = rd_q;
          resp_err_d   = 1'b0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      S_RESP: begin
        lsu.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A reset edge must never write memory, even mid-store.
  assign lsu.mem_we     = mem_we_raw & ~rst;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_rd    = resp_rd_q;
  assign lsu.resp_err   = resp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 5'd0;
      split_q      <= 1'b0;
      last_q       <= 2'd0;
      k_q          <= 2'd0;
      asm_q        <= '0;
      resp_rdata_q <= '0;
      resp_rd_q    <= 5'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      split_q      <= split_d;
      last_q       <= last_d;
      k_q          <= k_d;
      asm_q        <= asm_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: byte-array memory model on the
// memory port, expected responses queued at issue time and popped when
// resp_valid pulses, plus cycle-by-cycle checks of the beat sequence.
module tb_lsu_mem_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_initiator_if #(.WIDTH(32)) mif ();
  lsu_mem_initiator #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .lsu(mif));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_pass = 0, n_fail = 0, n_resp = 0, n_push = 0;

  // Sparse memory: addresses used here are distinct in {addr[16], addr[7:0]}.
  logic [7:0]  mem [512];
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  logic [7:0]  b0, b1, b2, b3;

  function automatic logic [8:0] midx(input logic [31:0] a);
    return {a[16], a[7:0]};
  endfunction

  always @(posedge clk) begin
    if (bd_we)           mem[midx(bd_addr)]      <= bd_data;
    else if (mif.mem_we) mem[midx(mif.mem_addr)] <= mif.mem_wdata[7:0];
  end

  always_comb begin
    b0 = mem[midx(mif.mem_addr)];
    b1 = mem[midx(mif.mem_addr + 32'd1)];
    b2 = mem[midx(mif.mem_addr + 32'd2)];
    b3 = mem[midx(mif.mem_addr + 32'd3)];
    mif.mem_rdata = '0;
    case (mif.mem_mode)
      3'b001:  mif.mem_rdata = {b3, b2, b1, b0};
      3'b010:  mif.mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b011:  mif.mem_rdata = {{24{b0[7]}}, b0};
      3'b100:  mif.mem_rdata = {16'b0, b1, b0};
      3'b101:  mif.mem_rdata = {24'b0, b0};
      default: mif.mem_rdata = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mif.resp_valid) begin
      n_resp++;
      if (sb.size() == 0) begin
        chk("resp_unexpected", n_resp, n_push);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rd", {27'b0, mif.resp_rd}, {27'b0, mon_e.rd});
        chk("resp_rdata", mif.resp_rdata, mon_e.rdata);
        chk("resp_err", {31'b0, mif.resp_err}, {31'b0, mon_e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] mode,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we);
    chk({tag, ".mode"},  {29'b0, mif.mem_mode}, {29'b0, mode});
    chk({tag, ".addr"},  mif.mem_addr, addr);
    chk({tag, ".wdata"}, mif.mem_wdata, wdata);
    chk({tag, ".we"},    {31'b0, mif.mem_we}, {31'b0, we});
  endtask

  // Waits (bounded) for req_ready, presents the request and steps past the
  // accepting edge; afterwards the bench is in cycle 1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input bit push);
    int t = 0;
    exp_t e;
    while (!mif.req_ready && t < 20) begin tick(); t++; end
    chk("ready_wait", {31'b0, mif.req_ready}, 32'd1);
    mif.req_valid = 1'b1; mif.req_we = we; mif.req_funct3 = f3;
    mif.req_addr = a; mif.req_wdata = wd; mif.req_rd = rd;
    if (push) begin
      e.rd = rd; e.rdata = exp_rdata; e.err = exp_err;
      sb.push_back(e);
      n_push++;
    end
    tick();
    mif.req_valid = 1'b0;
  endtask

  // Run an issued transaction to the end: n beats then the response cycle.
  task automatic finish_txn(input int n);
    for (int i = 1; i < n; i++) tick();
    tick();
    chk("resp_cycle", {31'b0, mif.resp_valid}, 32'd1);
    tick();
    chk("ready_back", {31'b0, mif.req_ready}, 32'd1);
  endtask

  initial begin
    mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_funct3 = 3'b000;
    mif.req_addr = '0; mif.req_wdata = '0; mif.req_rd = 5'd0;

    // Reset state; memory preload happens under reset.
    tick(); tick();
    chk("rst.ready", {31'b0, mif.req_ready}, 32'd1);
    chk("rst.resp_valid", {31'b0, mif.resp_valid}, 32'd0);
    chk("rst.resp_rdata", mif.resp_rdata, 32'd0);
    chk("rst.resp_rd", {27'b0, mif.resp_rd}, 32'd0);
    chk("rst.resp_err", {31'b0, mif.resp_err}, 32'd0);
    chk("rst.mode", {29'b0, mif.mem_mode}, 32'd0);
    poke(32'h10000, 8'h78); poke(32'h10001, 8'h56);
    poke(32'h10002, 8'h34); poke(32'h10003, 8'h12);
    poke(32'h10012, 8'hAA); poke(32'h10013, 8'hBB);
    poke(32'h10006, 8'h01); poke(32'h10007, 8'h02);
    rst = 1'b0;
    tick();

    // 1: aligned LW
    issue(1'b0, 3'b010, 32'h10000, 32'h0, 5'd5, 32'h12345678, 1'b0, 1'b1);
    chk_beat("lw.b0", 3'b001, 32'h10000, 32'h0, 1'b0);
    chk("lw.ready_busy", {31'b0, mif.req_ready}, 32'd0);
    chk("lw.no_resp_c1", {31'b0, mif.resp_valid}, 32'd0);
    tick();
    chk("lw.resp_c2", {31'b0, mif.resp_valid}, 32'd1);
    chk("lw.mode_idle", {29'b0, mif.mem_mode}, 32'd0);
    tick();
    chk("lw.ready_c3", {31'b0, mif.req_ready}, 32'd1);

    // 2: misaligned SW as four byte writes, then misaligned LW readback
    issue(1'b1, 3'b010, 32'h10002, 32'hDEADBEEF, 5'd6, 32'h0, 1'b0, 1'b1);
    chk_beat("sw.b0", 3'b011, 32'h10002, 32'hEF, 1'b1); tick();
    chk_beat("sw.b1", 3'b011, 32'h10003, 32'hBE, 1'b1); tick();
    chk_beat("sw.b2", 3'b011, 32'h10004, 32'hAD, 1'b1); tick();
    chk_beat("sw.b3", 3'b011, 32'h10005, 32'hDE, 1'b1); tick();
    chk("sw.resp_c5", {31'b0, mif.resp_valid}, 32'd1);
    tick();
    issue(1'b0, 3'b010, 32'h10002, 32'h0, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk_beat("lwm", 3'b101, 32'h10002 + k, 32'h0, 1'b0);
      tick();
    end
    chk("lwm.resp_c5", {31'b0, mif.resp_valid}, 32'd1);
    tick();

    // 3: half/byte loads with sign handling
    poke(32'h10001, 8'h80); poke(32'h10002, 8'hFF);
    issue(1'b0, 3'b001, 32'h10001, 32'h0, 5'd8, 32'hFFFFFF80, 1'b0, 1'b1);
    chk_beat("lh.b0", 3'b101, 32'h10001, 32'h0, 1'b0); tick();
    chk_beat("lh.b1", 3'b101, 32'h10002, 32'h0, 1'b0);
    finish_txn(1);
    issue(1'b0, 3'b101, 32'h10001, 32'h0, 5'd9, 32'h0000FF80, 1'b0, 1'b1);
    finish_txn(2);
    issue(1'b0, 3'b000, 32'h10001, 32'h0, 5'd10, 32'hFFFFFF80, 1'b0, 1'b1);
    chk_beat("lb.b0", 3'b011, 32'h10001, 32'h0, 1'b0);
    finish_txn(1);
    issue(1'b0, 3'b100, 32'h10001, 32'h0, 5'd11, 32'h00000080, 1'b0, 1'b1);
    chk_beat("lbu.b0", 3'b101, 32'h10001, 32'h0, 1'b0);
    finish_txn(1);
    issue(1'b0, 3'b001, 32'h10002, 32'h0, 5'd12, 32'hFFFFBEFF, 1'b0, 1'b1);
    chk_beat("lha.b0", 3'b010, 32'h10002, 32'h0, 1'b0);
    finish_txn(1);

    // 4: illegal funct3 (load 011, store 100)
    issue(1'b0, 3'b011, 32'h10000, 32'h0, 5'd13, 32'h0, 1'b1, 1'b1);
    chk_beat("ill_ld", 3'b000, 32'h0, 32'h0, 1'b0);
    chk("ill_ld.resp_c1", {31'b0, mif.resp_valid}, 32'd1);
    tick();
    issue(1'b1, 3'b100, 32'h10000, 32'hFFFFFFFF, 5'd14, 32'h0, 1'b1, 1'b1);
    chk_beat("ill_st", 3'b000, 32'h0, 32'h0, 1'b0);
    chk("ill_st.resp_c1", {31'b0, mif.resp_valid}, 32'd1);
    tick();

    // 5: reset during the third store beat
    issue(1'b1, 3'b010, 32'h10010, 32'h11223344, 5'd15, 32'h0, 1'b0, 1'b0);
    chk_beat("rsw.b0", 3'b011, 32'h10010, 32'h44, 1'b1); tick();
    chk_beat("rsw.b1", 3'b011, 32'h10011, 32'h33, 1'b1); tick();
    rst = 1'b1;
    #1;
    chk("rsw.b2_we_gated", {31'b0, mif.mem_we}, 32'd0);
    tick();
    rst = 1'b0;
    chk("rsw.ready", {31'b0, mif.req_ready}, 32'd1);
    chk("rsw.no_resp", {31'b0, mif.resp_valid}, 32'd0);
    tick(); tick();
    chk("rsw.m0", {24'b0, mem[midx(32'h10010)]}, 32'h44);
    chk("rsw.m1", {24'b0, mem[midx(32'h10011)]}, 32'h33);
    chk("rsw.m2", {24'b0, mem[midx(32'h10012)]}, 32'hAA);
    chk("rsw.m3", {24'b0, mem[midx(32'h10013)]}, 32'hBB);
    issue(1'b0, 3'b010, 32'h10010, 32'h0, 5'd16, 32'hBBAA3344, 1'b0, 1'b1);
    finish_txn(1);

    // 6: back-to-back requests with req_valid held high
    mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_funct3 = 3'b010;
    mif.req_addr = 32'h10000; mif.req_wdata = '0; mif.req_rd = 5'd17;
    sb.push_back('{rd: 5'd17, rdata: 32'hBEFF8078, err: 1'b0}); n_push++;
    tick();
    mif.req_addr = 32'h10004; mif.req_rd = 5'd18;
    sb.push_back('{rd: 5'd18, rdata: 32'h0201DEAD, err: 1'b0}); n_push++;
    chk_beat("q1.b0", 3'b001, 32'h10000, 32'h0, 1'b0);
    chk("q1.ready_c1", {31'b0, mif.req_ready}, 32'd0);
    tick();
    chk("q1.ready_c2", {31'b0, mif.req_ready}, 32'd0);
    tick();
    chk("q2.ready_c3", {31'b0, mif.req_ready}, 32'd1);
    chk("q2.not_yet", {29'b0, mif.mem_mode}, 32'd0);
    tick();
    mif.req_valid = 1'b0;
    chk_beat("q2.b0", 3'b001, 32'h10004, 32'h0, 1'b0);
    finish_txn(1);

    // Address wrap past 0xFFFFFFFF
    issue(1'b1, 3'b000, 32'hFFFFFFFF, 32'h0000005A, 5'd19, 32'h0, 1'b0, 1'b1);
    chk_beat("sb.b0", 3'b011, 32'hFFFFFFFF, 32'h5A, 1'b1);
    finish_txn(1);
    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000C3D4, 5'd20, 32'h0, 1'b0, 1'b1);
    chk_beat("sh.b0", 3'b011, 32'hFFFFFFFF, 32'hD4, 1'b1); tick();
    chk_beat("sh.b1", 3'b011, 32'h00000000, 32'hC3, 1'b1);
    finish_txn(1);
    issue(1'b0, 3'b100, 32'h00000000, 32'h0, 5'd21, 32'h000000C3, 1'b0, 1'b1);
    finish_txn(1);
    issue(1'b0, 3'b100, 32'hFFFFFFFF, 32'h0, 5'd22, 32'h000000D4, 1'b0, 1'b1);
    finish_txn(1);

    tick(); tick();
    chk("resp_count", n_resp, n_push);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
